// File: rtl/branch_commit_ctrl_if.sv
// req_if: valid/ready request channel between the commit ring and a
// commit controller.
//
// Handshake: the requester raises valid while its head entry wants to
// commit; the responder raises ready when it can take it. A transfer occurs
// on a rising clk edge where both valid and ready are high. valid may be
// held across cycles without a transfer.
//
// Signals:
//   valid - requester has an entry at head
//   ready - responder accepts the entry this cycle
interface req_if;
  logic valid;
  logic ready;

  modport source (output valid, input ready);
  modport sink   (input valid, output ready);
endinterface

// File: rtl/branch_commit_ctrl.sv
// branch_commit_ctrl: commits branch entries at the head of the commit ring
// and drives misprediction recovery.
//
// In-order resolutions from the branch unit are buffered in a small FIFO of
// {miss, target}. The ring's branch commit request is granted whenever the
// FIFO has a head entry. Committing a mispredicted branch produces a
// one-cycle flush and PC redirect. Issue then stays stalled for
// FLUSH_CYCLES cycles in total, counting the flush cycle.
//
// Build option: define BRANCH_STATS_EN to instantiate the committed-branch
// and committed-mispredict counters. Without it both outputs read 0.
//
// Ports:
//   clk, reset         - clock; synchronous active-high reset
//   commit_req_b       - req_if sink: valid from ring, ready from this block
//   br_res_valid/ready - resolution handshake from the branch unit
//   br_res_miss        - resolution is a mispredict
//   br_res_target      - correct next PC for a mispredict
//   flush              - one-cycle pulse clearing speculative state
//   redirect_valid     - fetch loads redirect_pc this cycle
//   redirect_pc        - recovery PC (last latched target)
//   issue_stall        - blocks issue into the ring
//   stat_branches      - committed branch count
//   stat_misses        - committed mispredict count
//   dbg_state          - FSM state: 0 RUN, 1 FLUSH, 2 HOLD
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Every ready here depends only on registered state and
// occupancy, never on the matching valid.
module branch_commit_ctrl #(
  parameter int FIFO_WIDTH   = 2,
  parameter int PC_WIDTH     = 14,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  req_if.sink                 commit_req_b,
  input  logic                br_res_valid,
  output logic                br_res_ready,
  input  logic                br_res_miss,
  input  logic [PC_WIDTH-1:0] br_res_target,
  output logic                flush,
  output logic                redirect_valid,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic                issue_stall,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_misses,
  output logic [1:0]          dbg_state
);

  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] FULL_COUNT = (FIFO_WIDTH + 1)'(DEPTH);
  localparam logic [FIFO_WIDTH:0] ONE_COUNT  = (FIFO_WIDTH + 1)'(1);
  // The hold counter only needs to hold FLUSH_CYCLES-2.
  localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD =
    (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         hold_cnt_q;
  logic [PC_WIDTH:0]     mem [DEPTH];
  logic [FIFO_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_WIDTH:0]   count_q;
  logic [PC_WIDTH-1:0]   redirect_q;

  logic                  in_run, fifo_full, commit_ready;
  logic                  push, commit_fire;
  logic [PC_WIDTH:0]     head;
  logic                  head_miss;
  logic [PC_WIDTH-1:0]   head_target;

  assign in_run      = (state_q == ST_RUN);
  assign fifo_full   = (count_q == FULL_COUNT);
  assign head        = mem[rd_ptr_q];
  assign head_miss   = head[PC_WIDTH];
  assign head_target = head[PC_WIDTH-1:0];
  assign commit_fire = commit_req_b.valid && commit_ready;
  // Outside RUN resolutions are swallowed: they are all wrong-path.
  assign push        = br_res_valid && in_run && !fifo_full;

  assign commit_req_b.ready = commit_ready;
  assign redirect_pc        = redirect_q;
  assign dbg_state          = state_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (commit_fire && head_miss) state_d = ST_FLUSH;
      ST_FLUSH: state_d = (FLUSH_CYCLES > 1) ? ST_HOLD : ST_RUN;
      ST_HOLD:  if (hold_cnt_q == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    flush          = 1'b0;
    redirect_valid = 1'b0;
    issue_stall    = 1'b0;
    commit_ready   = 1'b0;
    br_res_ready   = 1'b1;
    case (state_q)
      ST_RUN: begin
        commit_ready = (count_q != '0);
        br_res_ready = !fifo_full;
      end
      ST_FLUSH: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        issue_stall    = 1'b1;
      end
      ST_HOLD:  issue_stall = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                  hold_cnt_q <= '0;
    else if (state_q == ST_FLUSH) hold_cnt_q <= HOLD_LOAD;
    else if (state_q == ST_HOLD && hold_cnt_q != '0)
      hold_cnt_q <= hold_cnt_q - 1'b1;
  end

  // FIFO storage needs no reset; occupancy governs what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {br_res_miss, br_res_target};
  end

  // The FLUSH cycle empties the FIFO: everything behind a mispredict is
  // wrong-path.
  always_ff @(posedge clk) begin
    if (reset || state_q == ST_FLUSH) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (commit_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, commit_fire})
        2'b10:   count_q <= count_q + ONE_COUNT;
        2'b01:   count_q <= count_q - ONE_COUNT;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                         redirect_q <= '0;
    else if (commit_fire && head_miss) redirect_q <= head_target;
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branches_q, misses_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      branches_q <= '0;
      misses_q   <= '0;
    end else if (commit_fire) begin
      branches_q <= branches_q + 32'd1;
      if (head_miss) misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_branches = branches_q;
  assign stat_misses   = misses_q;
`else
  assign stat_branches = '0;
  assign stat_misses   = '0;
`endif

endmodule

// File: tb/tb_branch_commit_ctrl.sv
// Directed bench for branch_commit_ctrl (FIFO_WIDTH=2, PC_WIDTH=14,
// FLUSH_CYCLES=2). Inputs change 1 ns after a rising edge; outputs are
// checked at that same point, i.e. they show the state the edge produced.
module tb_branch_commit_ctrl;
  localparam int PW = 14;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  req_if commit_req_b_if ();
  logic          br_res_valid, br_res_ready, br_res_miss;
  logic [PW-1:0] br_res_target;
  logic          flush, redirect_valid, issue_stall;
  logic [PW-1:0] redirect_pc;
  logic [31:0]   stat_branches, stat_misses;
  logic [1:0]    dbg_state;

  branch_commit_ctrl #(.FIFO_WIDTH(2), .PC_WIDTH(PW), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .commit_req_b   (commit_req_b_if),
    .br_res_valid   (br_res_valid),
    .br_res_ready   (br_res_ready),
    .br_res_miss    (br_res_miss),
    .br_res_target  (br_res_target),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .issue_stall    (issue_stall),
    .stat_branches  (stat_branches),
    .stat_misses    (stat_misses),
    .dbg_state      (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // driver tasks
  task automatic offer(input logic v, input logic m, input logic [PW-1:0] t);
    br_res_valid  = v;
    br_res_miss   = m;
    br_res_target = t;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".flush"}, {31'd0, flush}, 32'd0);
    check({tag, ".rv"}, {31'd0, redirect_valid}, 32'd0);
    check({tag, ".stall"}, {31'd0, issue_stall}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    commit_req_b_if.valid = 1'b0;
    offer(1'b0, 1'b0, '0);
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check_quiet("rst");
    check("rst.rpc", 32'(redirect_pc), 32'd0);
    check("rst.ready", {31'd0, commit_req_b_if.ready}, 32'd0);
    check("rst.br_ready", {31'd0, br_res_ready}, 32'd1);
    check("rst.stat_b", stat_branches, 32'd0);
    check("rst.stat_m", stat_misses, 32'd0);
    check("rst.state", {30'd0, dbg_state}, {30'd0, S_RUN});

    // three non-miss results, ring valid throughout
    commit_req_b_if.valid = 1'b1;
    offer(1'b1, 1'b0, 14'h010);
    tick();
    check("t1.ready1", {31'd0, commit_req_b_if.ready}, 32'd1);
    check("t1.stat_b1", stat_branches, 32'd0);
    offer(1'b1, 1'b0, 14'h020);
    tick();
    check("t1.ready2", {31'd0, commit_req_b_if.ready}, 32'd1);
    check("t1.stat_b2", stat_branches, sx(1));
    offer(1'b1, 1'b0, 14'h030);
    tick();
    check("t1.ready3", {31'd0, commit_req_b_if.ready}, 32'd1);
    check_quiet("t1.mid");
    offer(1'b0, 1'b0, '0);
    tick();
    check("t1.ready4", {31'd0, commit_req_b_if.ready}, 32'd0);
    check_quiet("t1.end");
    check("t1.stat_b", stat_branches, sx(3));
    check("t1.stat_m", stat_misses, sx(0));

    // single mispredict, target 0x1A4
    commit_req_b_if.valid = 1'b0;
    offer(1'b1, 1'b1, 14'h1A4);
    tick();
    offer(1'b0, 1'b0, '0);
    check("t2.ready", {31'd0, commit_req_b_if.ready}, 32'd1);
    check("t2.pre_flush", {31'd0, flush}, 32'd0);
    commit_req_b_if.valid = 1'b1;
    tick();                                   // commit at N
    check("t2.flush", {31'd0, flush}, 32'd1);
    check("t2.rv", {31'd0, redirect_valid}, 32'd1);
    check("t2.rpc", 32'(redirect_pc), 32'h1A4);
    check("t2.stall1", {31'd0, issue_stall}, 32'd1);
    check("t2.ready_f", {31'd0, commit_req_b_if.ready}, 32'd0);
    check("t2.br_ready_f", {31'd0, br_res_ready}, 32'd1);
    check("t2.state_f", {30'd0, dbg_state}, {30'd0, S_FLUSH});
    tick();                                   // N+2
    check("t2.flush_h", {31'd0, flush}, 32'd0);
    check("t2.rv_h", {31'd0, redirect_valid}, 32'd0);
    check("t2.stall2", {31'd0, issue_stall}, 32'd1);
    check("t2.rpc_h", 32'(redirect_pc), 32'h1A4);
    check("t2.state_h", {30'd0, dbg_state}, {30'd0, S_HOLD});
    tick();                                   // N+3
    check("t2.stall3", {31'd0, issue_stall}, 32'd0);
    check("t2.state_r", {30'd0, dbg_state}, {30'd0, S_RUN});
    check("t2.ready_r", {31'd0, commit_req_b_if.ready}, 32'd0);
    check("t2.stat_b", stat_branches, sx(4));
    check("t2.stat_m", stat_misses, sx(1));

    // mispredict at head with two queued results behind it
    commit_req_b_if.valid = 1'b0;
    offer(1'b1, 1'b1, 14'h0F0);
    tick();
    offer(1'b1, 1'b0, 14'h0F4);
    tick();
    offer(1'b1, 1'b0, 14'h0F8);
    tick();
    offer(1'b0, 1'b0, '0);
    check("t3.br_ready", {31'd0, br_res_ready}, 32'd1);
    commit_req_b_if.valid = 1'b1;
    tick();
    check("t3.flush", {31'd0, flush}, 32'd1);
    check("t3.rpc", 32'(redirect_pc), 32'h0F0);
    tick();
    tick();
    check("t3.state_r", {30'd0, dbg_state}, {30'd0, S_RUN});
    check("t3.ready_r", {31'd0, commit_req_b_if.ready}, 32'd0);
    tick();
    check("t3.ready_r2", {31'd0, commit_req_b_if.ready}, 32'd0);
    check("t3.stat_b", stat_branches, sx(5));
    check("t3.stat_m", stat_misses, sx(2));

    // fill the FIFO with the ring idle
    commit_req_b_if.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 1'b0, 14'(16'h200 + i));
      tick();
    end
    check("t4.br_ready_full", {31'd0, br_res_ready}, 32'd0);
    check("t4.ready_full", {31'd0, commit_req_b_if.ready}, 32'd1);
    tick();                                   // offer held while full
    check("t4.br_ready_full2", {31'd0, br_res_ready}, 32'd0);
    offer(1'b0, 1'b0, '0);
    commit_req_b_if.valid = 1'b1;
    tick();
    check("t4.br_ready_after", {31'd0, br_res_ready}, 32'd1);
    tick();
    tick();
    check("t4.ready_last", {31'd0, commit_req_b_if.ready}, 32'd1);
    tick();
    check("t4.ready_empty", {31'd0, commit_req_b_if.ready}, 32'd0);
    check("t4.stat_b", stat_branches, sx(9));
    check_quiet("t4.end");

    // resolutions offered during FLUSH/HOLD are swallowed
    commit_req_b_if.valid = 1'b0;
    offer(1'b1, 1'b1, 14'h2AA);
    tick();
    offer(1'b0, 1'b0, '0);
    commit_req_b_if.valid = 1'b1;
    tick();
    check("t5.flush", {31'd0, flush}, 32'd1);
    offer(1'b1, 1'b0, 14'h2B0);
    check("t5.br_ready_f", {31'd0, br_res_ready}, 32'd1);
    tick();
    check("t5.state_h", {30'd0, dbg_state}, {30'd0, S_HOLD});
    check("t5.br_ready_h", {31'd0, br_res_ready}, 32'd1);
    tick();
    offer(1'b0, 1'b0, '0);
    check("t5.state_r", {30'd0, dbg_state}, {30'd0, S_RUN});
    check("t5.ready_r", {31'd0, commit_req_b_if.ready}, 32'd0);
    tick();
    check("t5.ready_r2", {31'd0, commit_req_b_if.ready}, 32'd0);
    check("t5.stat_b", stat_branches, sx(10));
    check("t5.stat_m", stat_misses, sx(3));

    // reset asserted while in HOLD
    commit_req_b_if.valid = 1'b0;
    offer(1'b1, 1'b1, 14'h3C3);
    tick();
    offer(1'b0, 1'b0, '0);
    commit_req_b_if.valid = 1'b1;
    tick();
    tick();
    check("t6.state_h", {30'd0, dbg_state}, {30'd0, S_HOLD});
    check("t6.stall_h", {31'd0, issue_stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6.state", {30'd0, dbg_state}, {30'd0, S_RUN});
    check_quiet("t6.rst");
    check("t6.ready", {31'd0, commit_req_b_if.ready}, 32'd0);
    check("t6.rpc", 32'(redirect_pc), 32'd0);
    check("t6.stat_b", stat_branches, 32'd0);
    tick();
    check_quiet("t6.after");
    check("t6.ready2", {31'd0, commit_req_b_if.ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
